// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES  = 4;
  localparam int unsigned FETCH_ADDR_W = 16;
  localparam int unsigned FETCH_DATA_W = 32;

  localparam logic [FETCH_ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0004;

  // One buffered fetch result: the instruction word and the PC it came from.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [31:0]             instr;
  } fetch_entry_t;

  // Force a byte address onto an instruction boundary.
  function automatic logic [FETCH_ADDR_W-1:0] align_pc(input logic [FETCH_ADDR_W-1:0] pc);
    return {pc[FETCH_ADDR_W-1:2], 2'b00};
  endfunction

  // True when the low address bits are not on an instruction boundary.
  function automatic logic is_misaligned(input logic [FETCH_ADDR_W-1:0] pc);
    return |pc[1:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer of fetch_entry_t with a registered head entry.
// Flush wins over push and pop; the head register holds its last value
// whenever the buffer is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetch_entry_t  din_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output fetch_entry_t  head_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  head_q, head_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Next-state for pointers, occupancy and the registered head entry.
  always_comb begin
    do_pop   = pop_i & ~flush_i & ~empty;
    do_push  = push_i & ~flush_i & (~full | do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (do_pop && !do_push) count_d = count_q - CW'(1);
      // The head comes straight from the input when the pushed word becomes
      // the only entry; otherwise a pop advances to the next stored entry.
      if ((empty && do_push) || (do_pop && do_push && count_q == CW'(1))) begin
        head_d = din_i;
      end else if (do_pop && count_q > CW'(1)) begin
        head_d = mem_q[rd_ptr_q + PW'(1)];
      end
    end
  end

  // Control and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Entry storage; contents are only read while the matching slot is occupied.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign full_o  = full;
  assign empty_o = empty;
  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses the combinational imem, buffers
// {pc, instr} pairs for decode and applies redirects with a full flush.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned                ADDR_BUS_WIDTH = FETCH_ADDR_W,
  parameter int unsigned                DATA_BUS_WIDTH = FETCH_DATA_W,
  parameter logic [ADDR_BUS_WIDTH-1:0]  RESET_PC       = DEFAULT_RESET_PC,
  parameter int unsigned                FIFO_DEPTH     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_en,
  output logic [ADDR_BUS_WIDTH-1:0] imem_addr,
  input  logic [DATA_BUS_WIDTH-1:0] imem_rd,
  input  logic                      redirect_valid,
  input  logic [ADDR_BUS_WIDTH-1:0] redirect_pc,
  output logic                      if_valid,
  input  logic                      if_ready,
  output logic [DATA_BUS_WIDTH-1:0] if_instr,
  output logic [ADDR_BUS_WIDTH-1:0] if_pc,
  output logic                      align_err
);

  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_BUS_WIDTH-1:0] pc_q, pc_d;
  logic                      align_err_q, align_err_d;
  logic                      pop, push;
  logic                      fifo_full, fifo_empty;
  logic [FCW-1:0]            fifo_count;
  fetch_entry_t              fifo_din, fifo_head;

  assign pop = if_valid & if_ready;

  // Push decision is combinational on if_ready so a full buffer can refill
  // in the same cycle it is drained.
  always_comb begin
    push = fetch_en & ~redirect_valid & (~fifo_full | pop);
  end

  // Captured fetch result: the current PC paired with the returned word.
  always_comb begin
    fifo_din       = '0;
    fifo_din.pc    = pc_q;
    fifo_din.instr = imem_rd;
  end

  // PC and sticky alignment error next-state; redirect outranks sequential fetch.
  always_comb begin
    pc_d        = pc_q;
    align_err_d = align_err_q;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
      if (is_misaligned(redirect_pc)) align_err_d = 1'b1;
    end else if (push) begin
      pc_d = pc_q + ADDR_BUS_WIDTH'(INSTR_BYTES);
    end
  end

  // PC and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      align_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      align_err_q <= align_err_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .din_i   (fifo_din),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  // Occupancy flags must agree with the reported count.
  a_fifo_flags : assert property (@(posedge clk) disable iff (!rst_n)
    (fifo_full == (fifo_count == FCW'(FIFO_DEPTH))) && (fifo_empty == (fifo_count == '0)));

  assign imem_addr = pc_q;
  assign if_valid  = ~fifo_empty;
  assign if_instr  = fifo_head.instr;
  assign if_pc     = fifo_head.pc;
  assign align_err = align_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a queue-based reference model.
module tb_instr_fetch;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_en = 1'b1;
  logic [15:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_instr;
  logic [15:0] if_pc;
  logic        align_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_BUS_WIDTH (16),
    .DATA_BUS_WIDTH (32),
    .RESET_PC       (16'h0004),
    .FIFO_DEPTH     (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .align_err      (align_err)
  );

  // Instruction memory contents; unlisted addresses return a tagged word.
  function automatic logic [31:0] imem_word(input logic [15:0] a);
    case (a)
      16'h0004: return 32'hFFC4A303;
      16'h0008: return 32'h0064A423;
      16'h000C: return 32'h0062E233;
      16'h0010: return 32'h00420C63;
      16'h0028: return 32'h0062E233;
      default:  return {16'hD00D, a};
    endcase
  endfunction

  assign imem_rd = imem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of fetched entries plus the next fetch PC.
  ent_t        q[$];
  logic [15:0] mpc = 16'h0004;
  logic        malign = 1'b0;
  ent_t        mlast = '{pc: 16'h0000, instr: 32'h0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mpc    = 16'h0004;
      malign = 1'b0;
      mlast  = '{pc: 16'h0000, instr: 32'h0};
    end else begin
      bit took;
      bit room;
      took = (q.size() != 0) && if_ready;
      if (redirect_valid) begin
        q.delete();
        if (redirect_pc[1:0] != 2'b00) malign = 1'b1;
        mpc = redirect_pc & 16'hFFFC;
      end else begin
        room = (q.size() < 2) || took;
        if (took) void'(q.pop_front());
        if (fetch_en && room) begin
          q.push_back('{pc: mpc, instr: imem_word(mpc)});
          mpc = mpc + 16'd4;
        end
      end
      if (q.size() != 0) mlast = q[0];
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    ent_t e;
    e = (q.size() != 0) ? q[0] : mlast;
    check("cmp_valid", 32'(if_valid), 32'(q.size() != 0));
    check("cmp_addr", 32'(imem_addr), 32'(mpc));
    check("cmp_align", 32'(align_err), 32'(malign));
    check("cmp_pc", 32'(if_pc), 32'(e.pc));
    check("cmp_instr", if_instr, e.instr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string name, input logic [15:0] pc, input logic [31:0] w);
    check({name, "_valid"}, 32'(if_valid), 32'd1);
    check({name, "_pc"}, 32'(if_pc), 32'(pc));
    check({name, "_instr"}, if_instr, w);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'h0004);
    check("rst_align", 32'(align_err), 32'd0);
    check("rst_pc", 32'(if_pc), 32'h0);
    check("rst_instr", if_instr, 32'h0);
    rst_n = 1'b1;

    // Streaming with decode always ready.
    tick(); head("s0", 16'h0004, 32'hFFC4A303);
    tick(); head("s1", 16'h0008, 32'h0064A423);
    tick(); head("s2", 16'h000C, 32'h0062E233);
    tick(); head("s3", 16'h0010, 32'h00420C63);

    // Asynchronous reset mid-stream.
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(if_valid), 32'd0);
    check("arst_addr", 32'(imem_addr), 32'h0004);
    if_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Backpressure for five cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      head("bp_head", 16'h0004, 32'hFFC4A303);
      if (i >= 1) check("bp_addr", 32'(imem_addr), 32'h000C);
    end
    if_ready = 1'b1;
    tick(); head("bp_r1", 16'h0008, 32'h0064A423);
    tick(); head("bp_r2", 16'h000C, 32'h0062E233);

    // Redirect while full.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    if_ready = 1'b0;
    repeat (3) tick();
    head("full_head", 16'h0004, 32'hFFC4A303);
    check("full_addr", 32'(imem_addr), 32'h000C);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0028;
    tick();
    check("rd_flush", 32'(if_valid), 32'd0);
    check("rd_addr", 32'(imem_addr), 32'h0028);
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    tick(); head("rd_h0", 16'h0028, 32'h0062E233);
    tick(); head("rd_h1", 16'h002C, 32'hD00D002C);

    // Redirect with a simultaneous pop: the popped entry is not replayed.
    redirect_valid = 1'b1;
    redirect_pc = 16'h0004;
    tick();
    check("rp_flush", 32'(if_valid), 32'd0);
    redirect_valid = 1'b0;
    tick(); head("rp_h0", 16'h0004, 32'hFFC4A303);
    tick(); head("rp_h1", 16'h0008, 32'h0064A423);

    // Misaligned redirect.
    redirect_valid = 1'b1;
    redirect_pc = 16'h002A;
    tick();
    check("mis_align", 32'(align_err), 32'd1);
    check("mis_addr", 32'(imem_addr), 32'h0028);
    redirect_valid = 1'b0;
    tick(); head("mis_h0", 16'h0028, 32'h0062E233);

    // Wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFC;
    tick();
    check("wrap_addr0", 32'(imem_addr), 32'hFFFC);
    redirect_valid = 1'b0;
    tick(); head("wrap_h0", 16'hFFFC, 32'hD00DFFFC);
    check("wrap_addr1", 32'(imem_addr), 32'h0000);
    tick(); head("wrap_h1", 16'h0000, 32'hD00D0000);
    check("wrap_align", 32'(align_err), 32'd1);

    // Fetch disabled: PC holds, a redirect still applies.
    fetch_en = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0010;
    tick();
    check("fe_addr", 32'(imem_addr), 32'h0010);
    redirect_valid = 1'b0;
    tick();
    check("fe_hold", 32'(imem_addr), 32'h0010);
    check("fe_valid", 32'(if_valid), 32'd0);
    fetch_en = 1'b1;
    tick(); head("fe_h0", 16'h0010, 32'h00420C63);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
